// File: rtl/apu_sound_scheduler_if.sv
// ---------------------------------------------------------------------------
// apu_sound_scheduler_if
// Groups the frame strobe, collision requests, mute control and the APU-facing
// outputs of the sound scheduler into one bundle.
//   master : game/test side, drives frame_end, req_eat/hit/die and mute,
//            observes the voice triggers and status.
//   slave  : the scheduler, consumes the requests and drives the outputs.
// ---------------------------------------------------------------------------
interface apu_sound_scheduler_if;
    logic       frame_end;
    logic       req_eat;
    logic       req_hit;
    logic       req_die;
    logic       mute;
    logic       saw_trigger;
    logic       square_trigger;
    logic       noise_trigger;
    logic [1:0] active_sound;
    logic       busy;
    logic       dropped;

    modport master (
        output frame_end, req_eat, req_hit, req_die, mute,
        input  saw_trigger, square_trigger, noise_trigger, active_sound, busy, dropped
    );

    modport slave (
        input  frame_end, req_eat, req_hit, req_die, mute,
        output saw_trigger, square_trigger, noise_trigger, active_sound, busy, dropped
    );
endinterface

// File: rtl/apu_sound_scheduler.sv
// ---------------------------------------------------------------------------
// apu_sound_scheduler
// Frame-synchronous scheduler between collision events and the three-voice
// APU. Rising edges of the request levels set one pending flag per sound
// class; on frame_end the highest-priority candidate (die > hit > eat) is
// started, preempts a lower sound, or retriggers the current one. Each sound
// plays for its *_FRAMES count and is followed by COOLDOWN_FRAMES of silence.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : slave side of apu_sound_scheduler_if
//           (frame_end, req_eat/hit/die, mute in;
//            saw/square/noise_trigger, active_sound, busy, dropped out)
// Sound codes (active_sound / cur): 0 none, 1 eat, 2 hit, 3 die. The code
// value doubles as the priority, so a numeric compare decides preemption.
// ---------------------------------------------------------------------------
module apu_sound_scheduler #(
    parameter int EAT_FRAMES      = 8,
    parameter int HIT_FRAMES      = 12,
    parameter int DIE_FRAMES      = 60,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int CNT_W           = 6
) (
    input logic                  clk,
    input logic                  reset,
    apu_sound_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PLAY, COOLDOWN} state_t;

    // Zero-length sounds are stretched to one frame.
    localparam logic [CNT_W-1:0] EAT_LEN = CNT_W'((EAT_FRAMES == 0) ? 1 : EAT_FRAMES);
    localparam logic [CNT_W-1:0] HIT_LEN = CNT_W'((HIT_FRAMES == 0) ? 1 : HIT_FRAMES);
    localparam logic [CNT_W-1:0] DIE_LEN = CNT_W'((DIE_FRAMES == 0) ? 1 : DIE_FRAMES);
    localparam logic [CNT_W-1:0] CD_LEN  = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       req_q;     // bit0 eat, bit1 hit, bit2 die
    logic [2:0]       pend_q, pend_d;
    logic             dropped_q, dropped_d;
    logic [2:0]       trig_q, trig_d;
    logic [1:0]       active_q, active_d;
    logic             busy_q, busy_d;

    logic [2:0] req_now;
    logic [2:0] rise;
    logic [2:0] pend_set;
    logic [2:0] clr;
    logic [1:0] cand;
    logic       start;
    logic       finish;

    function automatic logic [CNT_W-1:0] dur(input logic [1:0] code);
        case (code)
            2'd1:    dur = EAT_LEN;
            2'd2:    dur = HIT_LEN;
            default: dur = DIE_LEN;
        endcase
    endfunction

    assign req_now = {bus.req_die, bus.req_hit, bus.req_eat};

    always_comb begin
        rise     = req_now & ~req_q;
        // Same-cycle edges are already eligible as candidates.
        pend_set = pend_q | rise;
        if (pend_set[2])      cand = 2'd3;
        else if (pend_set[1]) cand = 2'd2;
        else if (pend_set[0]) cand = 2'd1;
        else                  cand = 2'd0;

        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        finish  = 1'b0;
        clr     = 3'b000;

        if (bus.frame_end) begin
            case (state_q)
                IDLE: start = (cand != 2'd0);
                PLAY: begin
                    // Higher priority preempts; equal priority retriggers.
                    if (cand != 2'd0 && cand >= cur_q) begin
                        start = 1'b1;
                    end else if (cnt_q <= ONE) begin
                        if (COOLDOWN_FRAMES == 0) begin
                            start  = (cand != 2'd0);
                            finish = 1'b1;
                        end else begin
                            state_d = COOLDOWN;
                            cur_d   = 2'd0;
                            cnt_d   = CD_LEN;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                COOLDOWN: begin
                    if (cnt_q <= ONE) begin
                        start  = (cand != 2'd0);
                        finish = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (start) begin
            state_d = PLAY;
            cur_d   = cand;
            cnt_d   = dur(cand);
            case (cand)
                2'd1:    clr = 3'b001;
                2'd2:    clr = 3'b010;
                2'd3:    clr = 3'b111;   // die also discards waiting eat/hit
                default: clr = 3'b000;
            endcase
        end else if (finish) begin
            state_d = IDLE;
            cur_d   = 2'd0;
            cnt_d   = '0;
        end

        pend_d    = pend_set & ~clr;
        dropped_d = (|(rise & pend_q)) | (start && cand == 2'd3 && (|pend_set[1:0]));
        busy_d    = (state_d != IDLE);
        active_d  = (state_d == PLAY) ? cur_d : 2'd0;
    end

    // One trigger per voice: eat->saw (code 1), hit->square (2), die->noise (3).
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_voice
            assign trig_d[gi] = (state_d == PLAY) && (cur_d == 2'(gi + 1)) && !bus.mute;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_q     <= 2'd0;
            cnt_q     <= '0;
            req_q     <= 3'b000;
            pend_q    <= 3'b000;
            dropped_q <= 1'b0;
            trig_q    <= 3'b000;
            active_q  <= 2'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            req_q     <= req_now;
            pend_q    <= pend_d;
            dropped_q <= dropped_d;
            trig_q    <= trig_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.saw_trigger    = trig_q[0];
    assign bus.square_trigger = trig_q[1];
    assign bus.noise_trigger  = trig_q[2];
    assign bus.active_sound   = active_q;
    assign bus.busy           = busy_q;
    assign bus.dropped        = dropped_q;

endmodule

// File: tb/tb_apu_sound_scheduler.sv
// ---------------------------------------------------------------------------
// tb_apu_sound_scheduler
// Two scheduler instances share random stimulus: one with the default timing
// and one with short sounds, a zero-length eat sound and no cooldown. A
// behavioural model (integer frame/cooldown counts and pending flags) predicts
// the registered outputs for each cycle; predictions are queued and a monitor
// compares them against the DUT outputs one cycle later.
// ---------------------------------------------------------------------------
module tb_apu_sound_scheduler;

    localparam int NCYC = 8000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apu_sound_scheduler_if bus_a ();
    apu_sound_scheduler_if bus_b ();

    apu_sound_scheduler #(
        .EAT_FRAMES(8), .HIT_FRAMES(12), .DIE_FRAMES(60),
        .COOLDOWN_FRAMES(2), .CNT_W(6)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    apu_sound_scheduler #(
        .EAT_FRAMES(0), .HIT_FRAMES(3), .DIE_FRAMES(5),
        .COOLDOWN_FRAMES(0), .CNT_W(6)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    // Model configuration per instance; index = sound code.
    int dur_tab [2][4];
    int cd_tab  [2];

    // Model state.
    bit prev_m [2][4];
    bit pend_m [2][4];
    int play_m [2];   // sound currently audible (0 none)
    int left_m [2];   // frames left in current sound
    int cool_m [2];   // silent frames left

    typedef struct packed {
        logic [6:0] a;
        logic [6:0] b;
    } exp_t;
    exp_t exp_q [$];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Expected outputs packed as {saw, square, noise, active[1:0], busy, dropped}.
    task automatic model_step(input int i, input bit rst, input bit fe,
                              input bit r_eat, input bit r_hit, input bit r_die,
                              input bit m, output logic [6:0] exp);
        bit r [4];
        bit drop;
        bit go;
        int best;
        r[0] = 1'b0; r[1] = r_eat; r[2] = r_hit; r[3] = r_die;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                prev_m[i][k] = 1'b0;
                pend_m[i][k] = 1'b0;
            end
            play_m[i] = 0;
            left_m[i] = 0;
            cool_m[i] = 0;
            exp = 7'd0;
        end else begin
            drop = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                if (r[k] && !prev_m[i][k]) begin
                    if (pend_m[i][k]) drop = 1'b1;
                    pend_m[i][k] = 1'b1;
                end
                prev_m[i][k] = r[k];
            end
            best = 0;
            for (int k = 1; k <= 3; k++) if (pend_m[i][k]) best = k;
            go = 1'b0;
            if (fe) begin
                if (play_m[i] != 0) begin
                    if (best >= play_m[i]) go = 1'b1;
                    else if (left_m[i] <= 1) begin
                        play_m[i] = 0;
                        if (cd_tab[i] > 0) cool_m[i] = cd_tab[i];
                        else go = (best != 0);
                    end else left_m[i] = left_m[i] - 1;
                end else if (cool_m[i] > 0) begin
                    if (cool_m[i] == 1) begin
                        cool_m[i] = 0;
                        go = (best != 0);
                    end else cool_m[i] = cool_m[i] - 1;
                end else begin
                    go = (best != 0);
                end
                if (go) begin
                    if (best == 3) begin
                        if (pend_m[i][1] || pend_m[i][2]) drop = 1'b1;
                        pend_m[i][1] = 1'b0;
                        pend_m[i][2] = 1'b0;
                    end
                    pend_m[i][best] = 1'b0;
                    play_m[i] = best;
                    left_m[i] = (dur_tab[i][best] < 1) ? 1 : dur_tab[i][best];
                    cool_m[i] = 0;
                end
            end
            exp = {play_m[i] == 1 && !m, play_m[i] == 2 && !m, play_m[i] == 3 && !m,
                   2'(play_m[i]), (play_m[i] != 0 || cool_m[i] > 0), drop};
        end
    endtask

    // Monitor: outputs after each edge are compared with the queued prediction.
    initial begin
        exp_t e;
        logic [6:0] act_a, act_b;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act_a = {bus_a.saw_trigger, bus_a.square_trigger, bus_a.noise_trigger,
                         bus_a.active_sound, bus_a.busy, bus_a.dropped};
                act_b = {bus_b.saw_trigger, bus_b.square_trigger, bus_b.noise_trigger,
                         bus_b.active_sound, bus_b.busy, bus_b.dropped};
                checks++;
                if (act_a === e.a) passes++;
                else $display("FAIL outputs_default cycle %0d: got %b expected %b (saw sq noise act busy drop)",
                              cyc, act_a, e.a);
                checks++;
                if (act_b === e.b) passes++;
                else $display("FAIL outputs_nocool cycle %0d: got %b expected %b (saw sq noise act busy drop)",
                              cyc, act_b, e.b);
            end
        end
    end

    // Stimulus driver.
    initial begin
        bit fe, re, rh, rd, mu, rs;
        exp_t e;
        dur_tab[0][0] = 0; dur_tab[0][1] = 8; dur_tab[0][2] = 12; dur_tab[0][3] = 60;
        dur_tab[1][0] = 0; dur_tab[1][1] = 0; dur_tab[1][2] = 3;  dur_tab[1][3] = 5;
        cd_tab[0] = 2;
        cd_tab[1] = 0;
        re = 1'b0; rh = 1'b0; rd = 1'b0; mu = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            cyc = c;
            rs = (c < 3) || ($urandom_range(0, 799) == 0);
            if (c < 3) re = 1'b1;   // request held through reset
            fe = ($urandom_range(0, 3) == 0);
            if (c >= 3) begin
                if ($urandom_range(0, 14) == 0)  re = ~re;
                if ($urandom_range(0, 24) == 0)  rh = ~rh;
                if ($urandom_range(0, 149) == 0) rd = ~rd;
                if ($urandom_range(0, 99) == 0)  mu = ~mu;
            end
            reset = rs;
            bus_a.frame_end = fe; bus_a.req_eat = re; bus_a.req_hit = rh;
            bus_a.req_die = rd;   bus_a.mute = mu;
            bus_b.frame_end = fe; bus_b.req_eat = re; bus_b.req_hit = rh;
            bus_b.req_die = rd;   bus_b.mute = mu;
            model_step(0, rs, fe, re, rh, rd, mu, e.a);
            model_step(1, rs, fe, re, rh, rd, mu, e.b);
            exp_q.push_back(e);
            @(posedge clk);
            #2;
        end
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
